// File: rtl/lsu_mem_controller.sv
// Load/store sequencer: one access at a time from the LS reservation station
// to the data-memory port, then a CDB broadcast of {tag, result}.
module lsu_mem_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         kill,
  input  logic         load_en,
  input  logic         store_en,
  input  logic [104:0] rs2exe,
  output logic         ready,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wstrb,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         cdb_req,
  input  logic         cdb_grant,
  output logic [37:0]  cdb_out,
  output logic         lsu_err,
  output logic [5:0]   err_tag,
  output logic [1:0]   err_code
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_DRAIN, S_CDB} state_t;

  // Counter value on the last cycle the request may be held without ack.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [2:0]  op_funct3;
  logic [5:0]  op_tag;
  logic [1:0]  op_lane;

  logic [2:0]  iss_funct3;
  logic [5:0]  iss_tag;
  logic [31:0] iss_addr;
  logic [31:0] iss_sdata;
  logic        iss_misaligned;
  logic [3:0]  iss_wstrb;
  logic [31:0] iss_wdata;

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  logic        issue_go;
  logic        issue_bad;
  logic        timeout_err;
  logic        mem_drop;
  logic        cdb_load;
  logic        cdb_done;

  assign iss_funct3 = rs2exe[104:102];
  assign iss_tag    = rs2exe[101:96];
  assign iss_sdata  = rs2exe[63:32];
  assign iss_addr   = rs2exe[95:64] + rs2exe[31:0];
  assign ready      = (state == S_IDLE);

  // Issue decode: alignment check, byte strobes and lane-replicated store data.
  always_comb begin
    iss_misaligned = 1'b0;
    iss_wstrb      = 4'b1111;
    iss_wdata      = iss_sdata;
    case (iss_funct3[1:0])
      2'b00: begin
        iss_wstrb = 4'b0001 << iss_addr[1:0];
        iss_wdata = {4{iss_sdata[7:0]}};
      end
      2'b01: begin
        iss_misaligned = iss_addr[0];
        iss_wstrb      = 4'b0011 << iss_addr[1:0];
        iss_wdata      = {2{iss_sdata[15:0]}};
      end
      default: iss_misaligned = |iss_addr[1:0];
    endcase
    if (!store_en) begin
      iss_wstrb = '0;
      iss_wdata = '0;
    end
  end

  // Load result: pick the addressed lane and extend according to funct3.
  always_comb begin
    case (op_lane)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_n     = state;
    issue_go    = 1'b0;
    issue_bad   = 1'b0;
    timeout_err = 1'b0;
    mem_drop    = 1'b0;
    cdb_load    = 1'b0;
    cdb_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!kill && (load_en || store_en)) begin
          if (iss_misaligned) begin
            issue_bad = 1'b1;
          end else begin
            issue_go = 1'b1;
            state_n  = S_MEM;
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          mem_drop = 1'b1;
          cdb_load = !kill;
          state_n  = kill ? S_IDLE : S_CDB;
        end else if (cnt == CNT_LAST) begin
          mem_drop    = 1'b1;
          timeout_err = !kill;
          state_n     = S_IDLE;
        end else if (kill) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack || cnt == CNT_LAST) begin
          mem_drop = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_CDB: begin
        if (kill || cdb_grant) begin
          cdb_done = 1'b1;
          state_n  = S_IDLE;
        end
      end
    endcase
  end

  // Registered outputs, operation record and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cdb_req   <= 1'b0;
      cdb_out   <= '0;
      lsu_err   <= 1'b0;
      err_tag   <= '0;
      err_code  <= '0;
      cnt       <= '0;
      op_funct3 <= '0;
      op_tag    <= '0;
      op_lane   <= '0;
    end else begin
      lsu_err  <= issue_bad || timeout_err;
      err_tag  <= issue_bad ? iss_tag : (timeout_err ? op_tag : '0);
      err_code <= issue_bad ? 2'b01 : (timeout_err ? 2'b10 : 2'b00);

      if (issue_go) begin
        mem_req   <= 1'b1;
        mem_we    <= store_en;
        mem_addr  <= {iss_addr[31:2], 2'b00};
        mem_wdata <= iss_wdata;
        mem_wstrb <= iss_wstrb;
        op_funct3 <= iss_funct3;
        op_tag    <= iss_tag;
        op_lane   <= iss_addr[1:0];
        cnt       <= '0;
      end else if (mem_drop) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_wstrb <= '0;
        cnt       <= '0;
      end else if (state == S_MEM || state == S_DRAIN) begin
        cnt <= cnt + 8'd1;
      end

      // mem_we still reflects the access type in the ack cycle.
      if (cdb_load) begin
        cdb_req <= 1'b1;
        cdb_out <= {op_tag, (mem_we ? 32'd0 : load_data)};
      end else if (cdb_done) begin
        cdb_req <= 1'b0;
        cdb_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Bench for lsu_mem_controller: directed literal checks plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_lsu_mem_controller;

  localparam int unsigned TMO       = 8;
  localparam int unsigned TMO_SHORT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, kill, load_en, store_en, mem_ack, cdb_grant;
  logic [104:0] rs2exe;
  logic [31:0]  mem_rdata;

  logic         ready, mem_req, mem_we, cdb_req, lsu_err;
  logic [31:0]  mem_addr, mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [37:0]  cdb_out;
  logic [5:0]   err_tag;
  logic [1:0]   err_code;

  logic         s_ready, s_mem_req, s_mem_we, s_cdb_req, s_lsu_err;
  logic [31:0]  s_mem_addr, s_mem_wdata;
  logic [3:0]   s_mem_wstrb;
  logic [37:0]  s_cdb_out;
  logic [5:0]   s_err_tag;
  logic [1:0]   s_err_code;

  lsu_mem_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .kill(kill), .load_en(load_en), .store_en(store_en),
    .rs2exe(rs2exe), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_out(cdb_out), .lsu_err(lsu_err),
    .err_tag(err_tag), .err_code(err_code)
  );

  lsu_mem_controller #(.TIMEOUT_CYCLES(TMO_SHORT)) dut_short (
    .clk(clk), .reset(reset), .kill(kill), .load_en(load_en), .store_en(store_en),
    .rs2exe(rs2exe), .ready(s_ready), .mem_req(s_mem_req), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_wstrb(s_mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cdb_req(s_cdb_req),
    .cdb_grant(cdb_grant), .cdb_out(s_cdb_out), .lsu_err(s_lsu_err),
    .err_tag(s_err_tag), .err_code(s_err_code)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          pend;
    bit          flushed;
    bit          cdb;
    bit          err;
    int unsigned waited;
    logic [2:0]  f3;
    logic [5:0]  tag;
    bit          st;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] data;
    logic [5:0]  etag;
    logic [1:0]  ecode;
  } model_t;

  model_t m;

  function automatic int unsigned size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
    int unsigned v, b, h;
    v = w >> (8 * addr[1:0]);
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input model_t c);
    int unsigned s;
    if (!c.st) return 4'd0;
    s = ((1 << size_bytes(c.f3)) - 1) << (c.addr % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input model_t c);
    case (size_bytes(c.f3))
      1:       return {24'd0, c.sdata[7:0]} * 32'h01010101;
      2:       return {16'd0, c.sdata[15:0]} * 32'h00010001;
      default: return c.sdata;
    endcase
  endfunction

  function automatic model_t step(input model_t c);
    model_t n;
    n = c;
    n.err = 1'b0;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    if (c.pend) begin
      n.waited = c.waited + 1;
      if (mem_ack) begin
        n.pend = 1'b0;
        if (!c.flushed && !kill) begin
          n.cdb  = 1'b1;
          n.data = c.st ? 32'd0 : load_value(c.f3, c.addr, mem_rdata);
        end
      end else if (n.waited == TMO) begin
        n.pend = 1'b0;
        if (!c.flushed && !kill) begin
          n.err = 1'b1; n.etag = c.tag; n.ecode = 2'b10;
        end
      end else if (kill) begin
        n.flushed = 1'b1;
      end
    end else if (c.cdb) begin
      if (kill || cdb_grant) n.cdb = 1'b0;
    end else if ((load_en || store_en) && !kill) begin
      n.f3    = rs2exe[104:102];
      n.tag   = rs2exe[101:96];
      n.sdata = rs2exe[63:32];
      n.addr  = rs2exe[95:64] + rs2exe[31:0];
      n.st    = store_en;
      if (n.addr % size_bytes(n.f3) != 0) begin
        n.err = 1'b1; n.etag = n.tag; n.ecode = 2'b01;
      end else begin
        n.pend = 1'b1; n.waited = 0; n.flushed = 1'b0;
      end
    end
    return n;
  endfunction

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge clk) m <= step(m);

  // Every-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ready", ready, !(m.pend || m.cdb));
      chk("mem_req", mem_req, m.pend);
      chk("cdb_req", cdb_req, m.cdb);
      chk("lsu_err", lsu_err, m.err);
      if (m.pend) begin
        chk("mem_we", mem_we, m.st);
        chk("mem_addr", mem_addr, m.addr & 32'hFFFF_FFFC);
        chk("mem_wstrb", mem_wstrb, exp_strb(m));
        if (m.st) chk("mem_wdata", mem_wdata, exp_wdata(m));
      end
      if (m.cdb) chk("cdb_out", cdb_out, {m.tag, m.data});
      if (m.err) begin
        chk("err_tag", err_tag, m.etag);
        chk("err_code", err_code, m.ecode);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [5:0] tag, input logic [31:0] base,
                        input logic [31:0] sdata, input logic [31:0] off, input bit st,
                        input logic [31:0] rdata, input logic [31:0] x_addr,
                        input logic [3:0] x_strb, input logic [31:0] x_wdata,
                        input logic [31:0] x_data);
    rs2exe   = {f3, tag, base, sdata, off};
    store_en = st;
    load_en  = !st;
    tick();
    load_en = 1'b0; store_en = 1'b0;
    chk("d_mem_req", mem_req, 1);
    chk("d_mem_we", mem_we, st);
    chk("d_mem_addr", mem_addr, x_addr);
    chk("d_mem_wstrb", mem_wstrb, x_strb);
    if (st) chk("d_mem_wdata", mem_wdata, x_wdata);
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0;
    chk("d_mem_req_drop", mem_req, 0);
    chk("d_cdb_req", cdb_req, 1);
    chk("d_cdb_out", cdb_out, {tag, x_data});
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    chk("d_ready", ready, 1);
    chk("d_cdb_req_drop", cdb_req, 0);
  endtask

  initial begin
    logic [31:0] base, sdata, off;
    reset = 1'b1; kill = 1'b0; load_en = 1'b0; store_en = 1'b0;
    mem_ack = 1'b0; cdb_grant = 1'b0; rs2exe = '0; mem_rdata = '0;
    tick();
    cmp_on = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cdb_req", cdb_req, 0);
    chk("rst_lsu_err", lsu_err, 0);
    tick();

    run_op(3'b010, 6'd5,  32'h100, 32'h0, 32'h4, 1'b0, 32'hDEADBEEF,
           32'h104, 4'b0000, 32'h0, 32'hDEADBEEF);
    run_op(3'b000, 6'd6,  32'h200, 32'h0, 32'h3, 1'b0, 32'h80112233,
           32'h200, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_op(3'b100, 6'd7,  32'h200, 32'h0, 32'h3, 1'b0, 32'h80112233,
           32'h200, 4'b0000, 32'h0, 32'h00000080);
    run_op(3'b001, 6'd8,  32'h300, 32'h0000ABCD, 32'h2, 1'b1, 32'h12345678,
           32'h300, 4'b1100, 32'hABCDABCD, 32'h0);
    run_op(3'b001, 6'd10, 32'h500, 32'h0, 32'h2, 1'b0, 32'h80011234,
           32'h500, 4'b0000, 32'h0, 32'hFFFF8001);
    run_op(3'b010, 6'd11, 32'hFFFFFFFC, 32'h0, 32'h8, 1'b0, 32'h0BADF00D,
           32'h4, 4'b0000, 32'h0, 32'h0BADF00D);
    run_op(3'b000, 6'd12, 32'h600, 32'h000000A5, 32'h1, 1'b1, 32'h0,
           32'h600, 4'b0010, 32'hA5A5A5A5, 32'h0);

    // Misaligned word load.
    rs2exe = {3'b010, 6'd9, 32'h400, 32'h0, 32'h1};
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    chk("mis_mem_req", mem_req, 0);
    chk("mis_lsu_err", lsu_err, 1);
    chk("mis_err_code", err_code, 2'b01);
    chk("mis_err_tag", err_tag, 6'd9);
    chk("mis_ready", ready, 1);
    tick();
    chk("mis_err_pulse_end", lsu_err, 0);

    // Kill while the access is outstanding, ack five cycles later.
    rs2exe = {3'b010, 6'd20, 32'h700, 32'h0, 32'h0};
    load_en = 1'b1;
    tick();
    load_en = 1'b0; kill = 1'b1;
    tick();
    kill = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      chk("km_mem_req", mem_req, 1);
      chk("km_cdb_req", cdb_req, 0);
      chk("km_ready", ready, 0);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("km_mem_req_drop", mem_req, 0);
    chk("km_no_cdb", cdb_req, 0);
    chk("km_ready_after", ready, 1);
    tick();
    chk("km_no_cdb_later", cdb_req, 0);

    // Kill during the CDB phase with grant low.
    rs2exe = {3'b010, 6'd21, 32'h800, 32'h0, 32'h0};
    load_en = 1'b1;
    tick();
    load_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11223344;
    tick();
    mem_ack = 1'b0;
    chk("kc_cdb_req", cdb_req, 1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kc_cdb_drop", cdb_req, 0);
    chk("kc_ready", ready, 1);

    // Timeout on the short-timeout instance, then reset mid-access on the main one.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rs2exe = {3'b010, 6'd33, 32'h900, 32'h0, 32'h0};
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("to_mem_req_held", s_mem_req, 1);
      chk("to_no_err_yet", s_lsu_err, 0);
      tick();
    end
    chk("to_mem_req_drop", s_mem_req, 0);
    chk("to_lsu_err", s_lsu_err, 1);
    chk("to_err_code", s_err_code, 2'b10);
    chk("to_err_tag", s_err_tag, 6'd33);
    chk("to_ready", s_ready, 1);
    chk("to_main_still_req", mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_ready", ready, 1);
    chk("mr_mem_req", mem_req, 0);
    chk("mr_mem_we", mem_we, 0);
    chk("mr_mem_addr", mem_addr, 0);
    chk("mr_mem_wdata", mem_wdata, 0);
    chk("mr_mem_wstrb", mem_wstrb, 0);
    chk("mr_cdb_req", cdb_req, 0);
    chk("mr_cdb_out", cdb_out, 0);
    chk("mr_lsu_err", lsu_err, 0);
    chk("mr_err_tag", err_tag, 0);
    chk("mr_err_code", err_code, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      base  = $urandom();
      sdata = $urandom();
      off   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom();
      rs2exe    = {3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), base, sdata, off};
      reset     = ($urandom_range(0, 299) == 0);
      kill      = ($urandom_range(0, 15) == 0);
      load_en   = ($urandom_range(0, 2) == 0);
      store_en  = ($urandom_range(0, 2) == 0);
      mem_ack   = ($urandom_range(0, 9) < 3);
      cdb_grant = ($urandom_range(0, 1) == 0);
      mem_rdata = $urandom();
      tick();
    end

    reset = 1'b0; kill = 1'b0; load_en = 1'b0; store_en = 1'b0;
    mem_ack = 1'b1; cdb_grant = 1'b1;
    tick();
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
